// File: rtl/aes_inv_round_ctrl.sv
// aes_inv_round_ctrl: iterative AES inverse-cipher round sequencer.
// Owns the 128-bit state register and the round counter. It drives the
// round-key index to an external key store and applies
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns, one round
// per clock.
// Optional macro AES_INV_CTRL_SBOX_SHARE_EN: four inverse S-boxes are
// time-shared, one 32-bit column per cycle, so every round takes 4 cycles.
// Handshake: a block moves on a rising edge where valid and ready are both
// high. in_ready is high only in IDLE and out_valid only in DONE. Neither
// depends combinationally on in_valid or out_ready.
// dbg_state exposes the FSM encoding (IDLE=0, ROUND=1, FINAL=2, DONE=3).
module aes_inv_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, FINAL = 2'd2, DONE = 2'd3} state_t;

  localparam logic [3:0] NR_IDX = 4'(NR);
  localparam logic [3:0] NR_M1  = 4'(NR - 1);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h00;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xtime(p);
    end
    return r;
  endfunction

  // Inverse affine transform followed by GF(2^8) inversion (x^254, 0 -> 0).
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] a;
    logic [7:0] p;
    logic [7:0] r;
    a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // Byte (row r, column c) sits at [127-8*(4c+r) -: 8]; row r rotates right by r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119 - 32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111 - 32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103 - 32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  state_t       st, st_nxt;
  logic [3:0]   cnt;
  logic [127:0] blk;
  logic [127:0] sr, sb, ark, imc;
  logic         step;

  assign sr  = inv_shift_rows(blk);
  assign ark = sb ^ rk_data;
  assign imc = inv_mix_columns(ark);

`ifdef AES_INV_CTRL_SBOX_SHARE_EN
  logic [1:0]   col;
  logic [127:0] sub_buf, sub_buf_nxt;
  logic [31:0]  sr_col;

  // Substitute column col of InvShiftRows(state); the round completes when col==3.
  always_comb begin
    sub_buf_nxt = sub_buf;
    sr_col      = sr[127 - 32*int'(col) -: 32];
    for (int b = 0; b < 4; b++)
      sub_buf_nxt[127 - 32*int'(col) - 8*b -: 8] = inv_sbox(sr_col[31 - 8*b -: 8]);
    sb   = sub_buf_nxt;
    step = (col == 2'd3);
  end

  // Column counter and substitution buffer advance only while a round runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col     <= 2'd0;
      sub_buf <= '0;
    end else if (st == ROUND || st == FINAL) begin
      col     <= col + 2'd1;
      sub_buf <= sub_buf_nxt;
    end else begin
      col     <= 2'd0;
    end
  end
`else
  // Full-width substitution: a whole round completes every cycle.
  always_comb begin
    sb   = inv_sub_bytes(sr);
    step = 1'b1;
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  // Next state and register-decoded outputs.
  always_comb begin
    st_nxt    = st;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rk_idx    = 4'd0;
    case (st)
      IDLE: begin
        in_ready = 1'b1;
        rk_idx   = NR_IDX;
        if (in_valid) st_nxt = ROUND;
      end
      ROUND: begin
        rk_idx = cnt;
        if (step && cnt == 4'd1) st_nxt = FINAL;
      end
      FINAL: begin
        rk_idx = 4'd0;
        if (step) st_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  // State block and round counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk <= '0;
      cnt <= 4'd0;
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          blk <= ciphertext ^ rk_data;
          cnt <= NR_M1;
        end
        ROUND: if (step) begin
          blk <= imc;
          if (cnt != 4'd1) cnt <= cnt - 4'd1;
        end
        FINAL: if (step) blk <= ark;
        default: ;
      endcase
    end
  end

  assign plaintext = blk;
  assign busy      = (st != IDLE);
  assign dbg_state = st;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// tb_aes_inv_round_ctrl: directed bench for the AES inverse round sequencer.
// A key store is built from a locally expanded key schedule. Expected
// plaintexts are queued on every accept and compared on every output
// handshake.
module tb_aes_inv_round_ctrl;

  localparam int NR = 10;
`ifdef AES_INV_CTRL_SBOX_SHARE_EN
  localparam int HOLD = 4;
`else
  localparam int HOLD = 1;
`endif
  localparam int LAT = NR * HOLD;

  localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] RK10_C1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk, rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] ciphertext, rk_data, plaintext;
  logic [3:0]   rk_idx;
  logic [1:0]   dbg_state;

  logic [127:0] rk_tab [16];
  logic [127:0] rk_junk;
  logic         rk_corrupt;
  logic [7:0]   sbox_t [256];

  logic [127:0] exp_q [$];
  int           acc_q [$];
  int           acc_log [$];
  logic [127:0] exp_pt_cur;
  logic         prev_ov;
  int           cyc;
  int           checks, failures;

  aes_inv_round_ctrl #(.NR(NR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ciphertext(ciphertext), .rk_idx(rk_idx), .rk_data(rk_data),
    .out_valid(out_valid), .out_ready(out_ready), .plaintext(plaintext),
    .busy(busy), .dbg_state(dbg_state)
  );

  assign rk_data = rk_corrupt ? rk_junk : rk_tab[rk_idx];

  // Clock and cycle counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Key-schedule model: forward S-box via brute-force inverse search.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    while (y != 8'h00) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_t[x] = s;
    end
  endtask

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon [10];
    rcon = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rcon[i/4 - 1], 24'h000000};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk_tab[r] = '0;
    for (int r = 0; r <= NR; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Driver: present one block and hold it until accepted.
  task automatic send(input logic [127:0] ct, input logic [127:0] pt);
    logic ok;
    @(posedge clk); #1;
    in_valid = 1'b1; ciphertext = ct; exp_pt_cur = pt;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    check("send_accept", 128'(ok), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; ciphertext = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_drain(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    check(tag, 128'(ok), 128'd1);
  endtask

  // Scoreboard: queue on accept, check latency on out_valid rise, compare on handshake.
  always @(negedge clk) begin
    int lat;
    if (!rst) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(exp_pt_cur);
        acc_q.push_back(cyc + 1);
        acc_log.push_back(cyc + 1);
      end
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) check("out_valid_without_accept", 128'(acc_q.size()), 128'd1);
        else begin
          lat = cyc - acc_q.pop_front();
          check("latency", 128'(lat), 128'(LAT));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("output_without_accept", 128'(exp_q.size()), 128'd1);
        else check("plaintext", plaintext, exp_q.pop_front());
      end
    end
    prev_ov = out_valid;
  end

  initial begin
    logic saw_ov;
    logic ok;
    int   n0;
    checks = 0; failures = 0; prev_ov = 1'b0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ciphertext = '0;
    rk_corrupt = 1'b0; rk_junk = {$urandom, $urandom, $urandom, $urandom};
    exp_pt_cur = '0;
    build_sbox();
    load_key(KEY_C1);
    check("key_schedule_rk10", rk_tab[10], RK10_C1);

    // Reset values.
    #2;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_rk_idx", 128'(rk_idx), 128'(NR));
    check("rst_plaintext", plaintext, 128'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // C.1 known answer with rk_idx trace; out_ready held low to create backpressure.
    @(posedge clk); #1;
    in_valid = 1'b1; ciphertext = CT_C1; exp_pt_cur = PT_C1;
    @(negedge clk);
    check("rk_idx_idle", 128'(rk_idx), 128'(NR));
    @(posedge clk); #1;
    in_valid = 1'b0; ciphertext = {$urandom, $urandom, $urandom, $urandom};
    for (int r = NR - 1; r >= 0; r--)
      for (int h = 0; h < HOLD; h++) begin
        @(negedge clk);
        check($sformatf("rk_idx_round_%0d", r), 128'(rk_idx), 128'(r));
      end
    @(negedge clk);
    check("done_out_valid", 128'(out_valid), 128'd1);

    // Backpressure: second block offered while DONE is stalled.
    @(posedge clk); #1;
    load_key(KEY_B);
    in_valid = 1'b1; ciphertext = CT_B; exp_pt_cur = PT_B;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_plaintext", plaintext, PT_C1);
      check("stall_in_ready", 128'(in_ready), 128'd0);
      check("stall_out_valid", 128'(out_valid), 128'd1);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    @(negedge clk);
    check("handshake_in_ready", 128'(in_ready), 128'd0);
    @(negedge clk);
    check("after_handshake_in_ready", 128'(in_ready), 128'd1);
    check("after_handshake_busy", 128'(busy), 128'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; ciphertext = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    check("second_accept_busy", 128'(busy), 128'd1);
    wait_drain("drain_block_b");

    // Asynchronous reset in the middle of round 5.
    load_key(KEY_C1);
    send(CT_C1, PT_C1);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rk_idx == 4'd5) begin ok = 1'b1; break; end
    end
    check("reach_round_5", 128'(ok), 128'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 128'(out_valid), 128'd0);
    check("arst_busy", 128'(busy), 128'd0);
    check("arst_in_ready", 128'(in_ready), 128'd1);
    check("arst_rk_idx", 128'(rk_idx), 128'(NR));
    check("arst_plaintext", plaintext, 128'd0);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    saw_ov = 1'b0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (out_valid) saw_ov = 1'b1;
    end
    check("no_out_valid_after_abort", 128'(saw_ov), 128'd0);
    send(CT_C1, PT_C1);
    wait_drain("drain_after_reset");

    // Idle noise: toggling out_ready and garbage rk_data must not disturb anything.
    rk_corrupt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(0, 1));
      rk_junk = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check("idle_busy", 128'(busy), 128'd0);
      check("idle_out_valid", 128'(out_valid), 128'd0);
      check("idle_plaintext", plaintext, PT_C1);
      check("idle_state", 128'(dbg_state), 128'd0);
    end
    rk_corrupt = 1'b0;

    // Back-to-back: in_valid and out_ready held high for two blocks.
    @(posedge clk); #1;
    out_ready = 1'b1;
    n0 = acc_log.size();
    in_valid = 1'b1; ciphertext = CT_C1; exp_pt_cur = PT_C1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (acc_log.size() >= n0 + 2) begin ok = 1'b1; break; end
    end
    #1 in_valid = 1'b0;
    check("b2b_two_accepts", 128'(ok), 128'd1);
    if (ok) check("b2b_accept_spacing", 128'(acc_log[n0+1] - acc_log[n0]), 128'(LAT + 2));
    wait_drain("drain_b2b");

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
